// File: rtl/latency_stats_if.sv
// latency_stats_if: measurement inputs and statistics outputs of latency_stats
interface latency_stats_if #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16,
  parameter int SUM_WIDTH = 32
);
  logic [WIDTH-1:0]     latency;
  logic                 running;
  logic                 enable;
  logic                 clear;
  logic [WIDTH-1:0]     last_latency;
  logic [WIDTH-1:0]     min_latency;
  logic [WIDTH-1:0]     max_latency;
  logic [SUM_WIDTH-1:0] sum_latency;
  logic [CNT_WIDTH-1:0] sample_count;
  logic                 stats_valid;
  logic                 sample_stb;
  logic                 sum_sat;
  logic                 count_sat;
  modport master (
    output latency, running, enable, clear,
    input  last_latency, min_latency, max_latency, sum_latency, sample_count,
           stats_valid, sample_stb, sum_sat, count_sat
  );
  modport slave (
    input  latency, running, enable, clear,
    output last_latency, min_latency, max_latency, sum_latency, sample_count,
           stats_valid, sample_stb, sum_sat, count_sat
  );
endinterface

// File: rtl/latency_stats.sv
// latency_stats: captures upstream latency at each measurement end and keeps
// last/min/max, saturating sum and count statistics.
module latency_stats #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16,
  parameter int SUM_WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  latency_stats_if.slave bus
);
  typedef enum logic {IDLE, MEAS} state_e;
  state_e               state_q, state_d;
  logic                 running_d_q, rise, fall, capture;
  logic [WIDTH-1:0]     last_q, min_q, max_q;
  logic [SUM_WIDTH-1:0] sum_q;
  logic [SUM_WIDTH:0]   sum_add;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_inc;
  logic                 valid_q, stb_q, sum_sat_q, cnt_sat_q;
  always_comb begin
    rise    = bus.running & ~running_d_q;
    fall    = ~bus.running & running_d_q;
    capture = (state_q == MEAS) && fall && !bus.clear;
    state_d = bus.clear ? IDLE :
              (state_q == IDLE && rise && bus.enable) ? MEAS :
              (state_q == MEAS && fall) ? IDLE : state_q;
    sum_add = (SUM_WIDTH+1)'(sum_q) + (SUM_WIDTH+1)'(bus.latency);
    cnt_inc = cnt_q + CNT_WIDTH'(1);
  end
  always_ff @(posedge clk) begin
    running_d_q <= reset ? 1'b0 : bus.running;
    if (reset || bus.clear) begin
      state_q   <= IDLE;
      last_q    <= '0;
      min_q     <= '1;
      max_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      stb_q     <= 1'b0;
      sum_sat_q <= 1'b0;
      cnt_sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= capture;
      if (capture) begin
        last_q  <= bus.latency;
        min_q   <= (bus.latency < min_q) ? bus.latency : min_q;
        max_q   <= (bus.latency > max_q) ? bus.latency : max_q;
        valid_q <= 1'b1;
        // sum and count freeze together once the count has saturated
        if (!cnt_sat_q) begin
          sum_q     <= sum_add[SUM_WIDTH] ? '1 : sum_add[SUM_WIDTH-1:0];
          sum_sat_q <= sum_sat_q | sum_add[SUM_WIDTH];
          cnt_q     <= cnt_inc;
          cnt_sat_q <= &cnt_inc;
        end
      end
    end
  end
  assign bus.last_latency = last_q;
  assign bus.min_latency  = min_q;
  assign bus.max_latency  = max_q;
  assign bus.sum_latency  = sum_q;
  assign bus.sample_count = cnt_q;
  assign bus.stats_valid  = valid_q;
  assign bus.sample_stb   = stb_q;
  assign bus.sum_sat      = sum_sat_q;
  assign bus.count_sat    = cnt_sat_q;
endmodule

// File: tb/tb_latency_stats.sv
// tb_latency_stats: table-driven and directed checks of latency_stats in a
// default instance and a narrow instance that exercises saturation.
module tb_latency_stats;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  latency_stats_if #(.WIDTH(16), .CNT_WIDTH(16), .SUM_WIDTH(32)) b0 ();
  latency_stats_if #(.WIDTH(8), .CNT_WIDTH(2), .SUM_WIDTH(8)) b1 ();
  latency_stats #(.WIDTH(16), .CNT_WIDTH(16), .SUM_WIDTH(32)) u0 (.clk(clk), .reset(reset), .bus(b0));
  latency_stats #(.WIDTH(8), .CNT_WIDTH(2), .SUM_WIDTH(8)) u1 (.clk(clk), .reset(reset), .bus(b1));
  int checks = 0;
  int errors = 0;
  int pulses0 = 0;
  int p;
  always @(posedge clk) if (b0.sample_stb === 1'b1) pulses0++;
  typedef struct {
    bit clr;
    int lat, len, e_last, e_min, e_max, e_sum, e_cnt;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_in(input int sel, input int lat, input logic run, input logic en, input logic clr);
    if (sel == 0) begin
      b0.latency = 16'(lat); b0.running = run; b0.enable = en; b0.clear = clr;
    end else begin
      b1.latency = 8'(lat); b1.running = run; b1.enable = en; b1.clear = clr;
    end
  endtask
  task automatic measure(input int sel, input int lat, input int len);
    set_in(sel, 0, 1'b1, 1'b1, 1'b0);
    repeat (len) tick();
    set_in(sel, lat, 1'b0, 1'b1, 1'b0);
    tick();
  endtask
  task automatic do_clear(input int sel);
    set_in(sel, 0, 1'b0, 1'b1, 1'b1);
    tick();
    set_in(sel, 0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic chk_cleared0(input string n);
    chk({n, " last"}, 64'(b0.last_latency), 0);
    chk({n, " min"}, 64'(b0.min_latency), 64'hFFFF);
    chk({n, " max"}, 64'(b0.max_latency), 0);
    chk({n, " sum"}, 64'(b0.sum_latency), 0);
    chk({n, " cnt"}, 64'(b0.sample_count), 0);
    chk({n, " valid"}, 64'(b0.stats_valid), 0);
    chk({n, " stb"}, 64'(b0.sample_stb), 0);
    chk({n, " sats"}, 64'({b0.sum_sat, b0.count_sat}), 0);
  endtask
  initial begin
    tbl[0] = '{1, 10, 10, 10, 10, 10, 10, 1};
    tbl[1] = '{1, 7, 3, 7, 7, 7, 7, 1};
    tbl[2] = '{0, 3, 2, 3, 3, 7, 10, 2};
    tbl[3] = '{0, 12, 4, 12, 3, 12, 22, 3};
    tbl[4] = '{0, 0, 1, 0, 0, 12, 22, 4};
    tbl[5] = '{0, 65535, 1, 65535, 0, 65535, 65557, 5};
    reset = 1'b1;
    set_in(0, 0, 1'b0, 1'b0, 1'b0);
    set_in(1, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    chk_cleared0("reset");
    chk("reset u1 min", 64'(b1.min_latency), 64'hFF);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].clr) do_clear(0);
      p = pulses0;
      measure(0, tbl[i].lat, tbl[i].len);
      chk($sformatf("row%0d last", i), 64'(b0.last_latency), 64'(tbl[i].e_last));
      chk($sformatf("row%0d min", i), 64'(b0.min_latency), 64'(tbl[i].e_min));
      chk($sformatf("row%0d max", i), 64'(b0.max_latency), 64'(tbl[i].e_max));
      chk($sformatf("row%0d sum", i), 64'(b0.sum_latency), 64'(tbl[i].e_sum));
      chk($sformatf("row%0d cnt", i), 64'(b0.sample_count), 64'(tbl[i].e_cnt));
      chk($sformatf("row%0d valid", i), 64'(b0.stats_valid), 1);
      chk($sformatf("row%0d stb", i), 64'(b0.sample_stb), 1);
      tick();
      chk($sformatf("row%0d stb low", i), 64'(b0.sample_stb), 0);
      chk($sformatf("row%0d pulses", i), 64'(pulses0 - p), 1);
    end
    // capture coincident with clear is dropped
    do_clear(0);
    measure(0, 5, 2);
    chk("pre-clear last", 64'(b0.last_latency), 5);
    set_in(0, 0, 1'b1, 1'b1, 1'b0);
    tick(); tick();
    p = pulses0;
    set_in(0, 9, 1'b0, 1'b1, 1'b1);
    tick();
    set_in(0, 9, 1'b0, 1'b1, 1'b0);
    chk_cleared0("capclr");
    tick();
    chk("capclr pulses", 64'(pulses0 - p), 0);
    // enable low at the rise: no capture even if enable rises before the fall
    set_in(0, 0, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(0, 0, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    set_in(0, 8, 1'b0, 1'b1, 1'b0);
    tick();
    chk("noen stb", 64'(b0.sample_stb), 0);
    chk("noen cnt", 64'(b0.sample_count), 0);
    // enable dropped during MEAS does not abort
    set_in(0, 0, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(0, 0, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(0, 6, 1'b0, 1'b0, 1'b0);
    tick();
    chk("endrop stb", 64'(b0.sample_stb), 1);
    chk("endrop cnt", 64'(b0.sample_count), 1);
    // back-to-back measurements with no dead cycles
    measure(0, 4, 1);
    measure(0, 2, 1);
    chk("b2b cnt", 64'(b0.sample_count), 3);
    chk("b2b sum", 64'(b0.sum_latency), 12);
    chk("b2b min", 64'(b0.min_latency), 2);
    chk("b2b stb", 64'(b0.sample_stb), 1);
    // clear during MEAS abandons the measurement
    set_in(0, 0, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(0, 0, 1'b1, 1'b1, 1'b1);
    tick();
    set_in(0, 0, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(0, 3, 1'b0, 1'b1, 1'b0);
    tick();
    chk_cleared0("clrmeas");
    // reset during MEAS discards it; running falls as reset releases
    set_in(0, 0, 1'b1, 1'b1, 1'b0);
    tick(); tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    set_in(0, 11, 1'b0, 1'b1, 1'b0);
    tick(); tick();
    chk_cleared0("rstmeas");
    // narrow instance: sum saturation
    do_clear(1);
    measure(1, 200, 2);
    chk("sat1 sum", 64'(b1.sum_latency), 200);
    chk("sat1 sum_sat", 64'(b1.sum_sat), 0);
    measure(1, 100, 2);
    chk("sat2 sum", 64'(b1.sum_latency), 255);
    chk("sat2 sum_sat", 64'(b1.sum_sat), 1);
    chk("sat2 cnt", 64'(b1.sample_count), 2);
    chk("sat2 count_sat", 64'(b1.count_sat), 0);
    // narrow instance: count saturation freezes sum and count
    do_clear(1);
    chk("clr1 sum_sat", 64'(b1.sum_sat), 0);
    measure(1, 1, 1);
    measure(1, 2, 1);
    chk("cnt2 count_sat", 64'(b1.count_sat), 0);
    measure(1, 3, 1);
    chk("cnt3 cnt", 64'(b1.sample_count), 3);
    chk("cnt3 count_sat", 64'(b1.count_sat), 1);
    chk("cnt3 sum", 64'(b1.sum_latency), 6);
    measure(1, 4, 1);
    chk("cnt4 cnt", 64'(b1.sample_count), 3);
    chk("cnt4 sum", 64'(b1.sum_latency), 6);
    chk("cnt4 last", 64'(b1.last_latency), 4);
    chk("cnt4 max", 64'(b1.max_latency), 4);
    chk("cnt4 min", 64'(b1.min_latency), 1);
    chk("cnt4 stb", 64'(b1.sample_stb), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
